// File: rtl/ex_stage_hs_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_stage_hs_if                                                |
// | Purpose  : Bundles the execute-stage handshake and operand bus between   |
// |            the ID->EX register side, the EX controller and MEM.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Signals (direction as seen by the EX controller, i.e. modport slave):   |
// |   ex_valid_i        in   EX holds a valid instruction                    |
// |   is_div_i          in   instruction uses the divider                    |
// |   is_signed_i       in   signed divide (div.w / mod.w)                   |
// |   want_rem_i        in   return remainder instead of quotient            |
// |   src1_i            in   dividend                                        |
// |   src2_i            in   divisor                                         |
// |   alu_result_i      in   single-cycle ALU result                         |
// |   mem_allowin_i     in   MEM stage can accept                            |
// |   flush_i           in   kill EX contents this cycle                     |
// |   ex_allowin_o      out  EX accepts a new instruction at next edge       |
// |   ex_to_mem_valid_o out  EX result valid toward MEM                      |
// |   ex_result_o       out  result for the EX->MEM bus                      |
// |   div_busy_o        out  divider not idle                                |
// +--------------------------------------------------------------------------+
interface ex_stage_hs_if #(
  parameter int DATA_W = 32
);
  logic              ex_valid_i;
  logic              is_div_i;
  logic              is_signed_i;
  logic              want_rem_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [DATA_W-1:0] alu_result_i;
  logic              mem_allowin_i;
  logic              flush_i;
  logic              ex_allowin_o;
  logic              ex_to_mem_valid_o;
  logic [DATA_W-1:0] ex_result_o;
  logic              div_busy_o;

  // Upstream/environment side: drives the instruction and MEM/flush controls.
  modport master (
    output ex_valid_i, is_div_i, is_signed_i, want_rem_i,
    output src1_i, src2_i, alu_result_i, mem_allowin_i, flush_i,
    input  ex_allowin_o, ex_to_mem_valid_o, ex_result_o, div_busy_o
  );

  // EX controller side.
  modport slave (
    input  ex_valid_i, is_div_i, is_signed_i, want_rem_i,
    input  src1_i, src2_i, alu_result_i, mem_allowin_i, flush_i,
    output ex_allowin_o, ex_to_mem_valid_o, ex_result_o, div_busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_stage_hs                                                   |
// | Purpose  : Execute-stage valid/allowin controller with a 32-step         |
// |            restoring divider. Single-cycle ops pass straight through;    |
// |            divides hold EX for 33 cycles before presenting a result.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports:                                                                   |
// |   clk    in  clock                                                       |
// |   rst_n  in  synchronous active-low reset                                |
// |   bus    ex_stage_hs_if.slave - instruction/operand inputs, MEM and      |
// |          flush controls, allowin/valid/result/busy outputs               |
// | Parameters:                                                              |
// |   DATA_W operand/result width (32)                                       |
// |   CNT_W  iteration counter width                                         |
// +--------------------------------------------------------------------------+
module ex_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_stage_hs_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // FSM
  logic [1:0]        state_q, state_d;
  // Divider datapath
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;     // dividend shifts out MSB, quotient shifts in LSB
  logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder
  logic [DATA_W-1:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dvz_q, dvz_d;     // divide by zero seen at start

  // Handshake
  logic              ready_go;
  logic              div_busy;
  logic              start;
  logic              to_mem_valid;
  logic              handshake;

  // Step arithmetic
  logic [DATA_W-1:0] src1_abs, src2_abs;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] step_quo, step_rem;
  logic [DATA_W-1:0] fix_quo, fix_rem;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign start        = bus.ex_valid_i & bus.is_div_i & ~bus.flush_i;
  assign to_mem_valid = bus.ex_valid_i & ready_go & ~bus.flush_i;
  assign handshake    = to_mem_valid & bus.mem_allowin_i;

  assign bus.ex_to_mem_valid_o = to_mem_valid;
  assign bus.ex_allowin_o      = ~bus.ex_valid_i | (ready_go & bus.mem_allowin_i) | bus.flush_i;
  assign bus.ex_result_o       = bus.is_div_i ? (bus.want_rem_i ? rem_q : quo_q) : bus.alu_result_i;
  assign bus.div_busy_o        = div_busy;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)              state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == LAST_CNT)  state_d = ST_DONE;
      ST_DONE: if (handshake)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    // A flush kills whatever EX holds, including a divide in progress.
    if (bus.flush_i) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    ready_go = ~bus.is_div_i | (state_q == ST_DONE);
    div_busy = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------------
  // Divider step
  // ---------------------------------------------------------------------
  always_comb begin
    src1_abs = (bus.is_signed_i & bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
    src2_abs = (bus.is_signed_i & bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;

    // Bring down the next dividend bit and try to subtract the divisor.
    trial = {rem_q, quo_q[DATA_W-1]};
    diff  = trial - {1'b0, dvsr_q};
    if (diff[DATA_W]) begin
      // Borrow: restore, quotient bit 0.  trial fits in DATA_W here.
      step_rem = trial[DATA_W-1:0];
      step_quo = {quo_q[DATA_W-2:0], 1'b0};
    end else begin
      step_rem = diff[DATA_W-1:0];
      step_quo = {quo_q[DATA_W-2:0], 1'b1};
    end

    // Divide by zero leaves the all-ones quotient untouched regardless of
    // the dividend's sign; the remainder magnitude already equals |src1|.
    fix_quo = (quo_neg_q & ~dvz_q) ? -step_quo : step_quo;
    fix_rem = rem_neg_q ? -step_rem : step_rem;
  end

  // ---------------------------------------------------------------------
  // Divider next-state
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dvz_d     = dvz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          quo_d     = src1_abs;
          rem_d     = '0;
          dvsr_d    = src2_abs;
          quo_neg_d = bus.is_signed_i & (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
          rem_neg_d = bus.is_signed_i & bus.src1_i[DATA_W-1];
          dvz_d     = (bus.src2_i == '0);
        end
      end
      ST_BUSY: begin
        if (!bus.flush_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            quo_d = fix_quo;
            rem_d = fix_rem;
          end else begin
            quo_d = step_quo;
            rem_d = step_rem;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Divider registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dvz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dvz_q     <= dvz_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_stage_hs                                                |
// | Purpose  : Self-checking bench for ex_stage_hs. A driver models the      |
// |            ID->EX register, an expected-result queue is filled at issue, |
// |            and a monitor pops/compares on each EX->MEM valid.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ex_stage_hs;

  typedef struct {
    logic [31:0] res;
    logic        is_div;
    int          t_issue;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t sb_q[$];
  exp_t e_m;
  bit   seen_first;
  bit   expect_idle;

  bit   bp_rand;
  int   bp_from;
  int   bp_n;

  ex_stage_hs_if #(.DATA_W(32)) bus ();

  ex_stage_hs #(.DATA_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MEM-side acceptance: random, or low for a chosen window of cycles.
  always @(posedge clk) begin
    #1;
    if (bp_rand) bus.mem_allowin_i = ($urandom_range(0, 3) != 0);
    else         bus.mem_allowin_i = !(cyc >= bp_from && cyc < bp_from + bp_n);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [31:0] ref_div(input logic sg, input logic wr,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return wr ? a : 32'hFFFF_FFFF;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return wr ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Present one instruction and hold it until EX accepts it. Called just
  // after a rising edge; returns just after the edge that consumed it.
  task automatic send(input logic dv, input logic sg, input logic wr,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu);
    int   t0;
    bit   done;
    logic exp_allow;
    exp_t e;
    bus.ex_valid_i   = 1'b1;
    bus.is_div_i     = dv;
    bus.is_signed_i  = sg;
    bus.want_rem_i   = wr;
    bus.src1_i       = a;
    bus.src2_i       = b;
    bus.alu_result_i = alu;
    bus.flush_i      = 1'b0;
    t0 = cyc;
    e.res     = dv ? ref_div(sg, wr, a, b) : alu;
    e.is_div  = dv;
    e.t_issue = t0;
    sb_q.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      exp_allow = (!dv || cyc >= t0 + 33) && bus.mem_allowin_i;
      chk1("allowin", bus.ex_allowin_o, exp_allow);
      if (dv) begin
        chk1("div_valid", bus.ex_to_mem_valid_o, cyc >= t0 + 33);
        chk1("div_busy", bus.div_busy_o, cyc > t0);
      end
      done = bus.ex_allowin_o;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instruction issued at cycle %0d never accepted", t0);
      summary_and_finish();
    end
  endtask

  task automatic idle(input int n);
    bus.ex_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a divide outside the scoreboard (used for flush/reset aborts).
  task automatic start_div_raw(input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid_i  = 1'b1;
    bus.is_div_i    = 1'b1;
    bus.is_signed_i = 1'b0;
    bus.want_rem_i  = 1'b0;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.flush_i     = 1'b0;
  endtask

  // Monitor: every cycle EX presents valid, compare against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expect_idle) begin
        chk1("idle_after_div", bus.div_busy_o, 1'b0);
        expect_idle = 1'b0;
      end
      if (bus.ex_to_mem_valid_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: result %h with empty queue (cycle %0d)",
                   bus.ex_result_o, cyc);
        end else begin
          e_m = sb_q[0];
          chk("result", bus.ex_result_o, e_m.res);
          if (!seen_first) begin
            seen_first = 1'b1;
            chk("latency", 32'(cyc - e_m.t_issue), e_m.is_div ? 32'd33 : 32'd0);
          end
          if (bus.mem_allowin_i) begin
            void'(sb_q.pop_front());
            seen_first = 1'b0;
            if (e_m.is_div) expect_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary_and_finish();
  end

  initial begin
    logic        dv, sg, wr;
    logic [31:0] a, b;
    int          gap;
    checks      = 0;
    errors      = 0;
    seen_first  = 1'b0;
    expect_idle = 1'b0;
    bp_rand     = 1'b0;
    bp_from     = 0;
    bp_n        = 0;
    rst_n             = 1'b0;
    bus.ex_valid_i    = 1'b0;
    bus.is_div_i      = 1'b1;
    bus.is_signed_i   = 1'b0;
    bus.want_rem_i    = 1'b0;
    bus.src1_i        = 32'd0;
    bus.src2_i        = 32'd0;
    bus.alu_result_i  = 32'hDEAD_BEEF;
    bus.mem_allowin_i = 1'b1;
    bus.flush_i       = 1'b0;

    // Reset state: registered quotient/remainder cleared, EX open.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_allowin", bus.ex_allowin_o, 1'b1);
    chk1("rst_valid", bus.ex_to_mem_valid_o, 1'b0);
    chk1("rst_busy", bus.div_busy_o, 1'b0);
    chk("rst_quo", bus.ex_result_o, 32'd0);
    bus.want_rem_i = 1'b1;
    @(negedge clk);
    chk("rst_rem", bus.ex_result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle op.
    send(1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'h1234);
    idle(1);

    // Directed divides.
    send(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0);
    idle(1);
    send(1'b1, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0);
    send(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0);
    send(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0);
    send(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    send(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    send(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0);
    send(1'b1, 1'b0, 1'b1, 32'd5, 32'd0, 32'd0);
    send(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'd0);
    send(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd0);
    send(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hCAFE_F00D);

    // MEM holds off for 4 cycles once the divide is DONE.
    bp_from = cyc + 33;
    bp_n    = 4;
    send(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, 32'd0);
    bp_n    = 0;
    idle(2);

    // Flush during BUSY.
    start_div_raw(32'd50, 32'd5);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk1("flush_busy_valid", bus.ex_to_mem_valid_o, 1'b0);
    chk1("flush_busy_allowin", bus.ex_allowin_o, 1'b1);
    @(posedge clk);
    #1;
    bus.flush_i    = 1'b0;
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    chk1("flush_busy_idle", bus.div_busy_o, 1'b0);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 1'b0, 32'd77, 32'd8, 32'd0);
    send(1'b1, 1'b0, 1'b1, 32'd77, 32'd8, 32'd0);

    // Flush in the DONE cycle wins over the handshake.
    start_div_raw(32'd9, 32'd2);
    repeat (33) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk1("flush_done_valid", bus.ex_to_mem_valid_o, 1'b0);
    chk1("flush_done_allowin", bus.ex_allowin_o, 1'b1);
    @(posedge clk);
    #1;
    bus.flush_i    = 1'b0;
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    chk1("flush_done_idle", bus.div_busy_o, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-divide.
    start_div_raw(32'd123456, 32'd789);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    rst_n          = 1'b0;
    bus.ex_valid_i = 1'b0;
    bus.want_rem_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("midrst_busy", bus.div_busy_o, 1'b0);
    chk1("midrst_allowin", bus.ex_allowin_o, 1'b1);
    chk1("midrst_valid", bus.ex_to_mem_valid_o, 1'b0);
    chk("midrst_quo", bus.ex_result_o, 32'd0);
    bus.want_rem_i = 1'b1;
    @(negedge clk);
    chk("midrst_rem", bus.ex_result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'd0);

    // Randomized mix with random MEM backpressure.
    bp_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      dv  = ($urandom_range(0, 2) != 0);
      sg  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      a   = pick_operand();
      b   = pick_operand();
      send(dv, sg, wr, a, b, $urandom);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end
    bp_rand = 1'b0;
    idle(5);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never presented, expected 0", sb_q.size());
    end

    summary_and_finish();
  end

endmodule
`default_nettype wire
